// File: rtl/fitness_evaluator_pkg.sv
// Shared types and default sizes for the fitness evaluator.
// Build option: FITNESS_SATURATE_EN selects saturating (vs wrapping) accumulation.
package fitness_evaluator_pkg;
    localparam int SCORE_W                 = 16;
    localparam int NETWORKS_PER_POPULATION = 16;
    localparam int NET_IDX_W               = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fe_state_t;
endpackage

// File: rtl/fitness_popcount.sv
// Counts how many network output bits match their target bits.
module fitness_popcount #(
    parameter int OUTPUT_COUNT = 1,
    parameter int INC_W        = 1
) (
    input  logic [OUTPUT_COUNT-1:0] nout,
    input  logic [OUTPUT_COUNT-1:0] target,
    output logic [INC_W-1:0]        count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++)
            count = count + INC_W'(~(nout[i] ^ target[i]));
    end
endmodule

// File: rtl/fitness_evaluator.sv
// Scores each network of a population by counting matching output bits, keeps a
// per-network score table and tracks the best network. Build option: FITNESS_SATURATE_EN.
module fitness_evaluator
    import fitness_evaluator_pkg::*;
#(
    parameter int OUTPUT_COUNT            = 1,
    parameter int NETWORKS_PER_POPULATION = fitness_evaluator_pkg::NETWORKS_PER_POPULATION,
    parameter int SCORE_W                 = fitness_evaluator_pkg::SCORE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              networkState,
    input  logic [NET_IDX_W-1:0]    activeNetwork,
    input  logic                    networkFinished,
    input  logic                    sampleEn,
    input  logic [OUTPUT_COUNT-1:0] nout,
    input  logic [OUTPUT_COUNT-1:0] target,
    input  logic [NET_IDX_W-1:0]    rdIndex,
    output logic [SCORE_W-1:0]      rdScore,
    output logic [NET_IDX_W-1:0]    bestNetwork,
    output logic [SCORE_W-1:0]      bestScore,
    output logic                    scoresValid,
    output logic                    scoreOverflow
);
    localparam int INC_W = $clog2(OUTPUT_COUNT + 1);
    localparam logic [NET_IDX_W:0] NPOP = (NET_IDX_W + 1)'(NETWORKS_PER_POPULATION);

    fe_state_t            state;
    logic [SCORE_W-1:0]   acc;
    logic [NET_IDX_W-1:0] prev_net;
    logic [SCORE_W-1:0]   score_tbl [NETWORKS_PER_POPULATION];

    logic [INC_W-1:0]     match_cnt;
    logic [SCORE_W-1:0]   inc;
    logic [SCORE_W:0]     sum;
    logic [SCORE_W-1:0]   acc_next;
    logic                 running;
    logic                 commit;

    fitness_popcount #(.OUTPUT_COUNT(OUTPUT_COUNT), .INC_W(INC_W)) u_popcount (
        .nout   (nout),
        .target (target),
        .count  (match_cnt)
    );

    assign inc = sampleEn ? SCORE_W'(match_cnt) : '0;
    assign sum = {1'b0, acc} + {1'b0, inc};

`ifdef FITNESS_SATURATE_EN
    assign acc_next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
`else
    assign acc_next = sum[SCORE_W-1:0];
`endif

    // A network's score is committed when the loader moves on or signals the end.
    assign running = (state == RUN) && (networkState == 2'd1);
    assign commit  = running && (networkFinished || (activeNetwork != prev_net))
                     && ({1'b0, prev_net} < NPOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            prev_net      <= '0;
            rdScore       <= '0;
            bestNetwork   <= '0;
            bestScore     <= '0;
            scoresValid   <= 1'b0;
            scoreOverflow <= 1'b0;
            for (int i = 0; i < NETWORKS_PER_POPULATION; i++) score_tbl[i] <= '0;
        end else begin
            rdScore <= ({1'b0, rdIndex} < NPOP) ? score_tbl[rdIndex] : '0;
            case (state)
                IDLE: if (networkState == 2'd1) begin
                    for (int i = 0; i < NETWORKS_PER_POPULATION; i++) score_tbl[i] <= '0;
                    acc           <= '0;
                    bestScore     <= '0;
                    bestNetwork   <= '0;
                    scoresValid   <= 1'b0;
                    scoreOverflow <= 1'b0;
                    prev_net      <= activeNetwork;
                    state         <= RUN;
                end
                RUN: begin
                    if (networkState != 2'd1) begin
                        state <= IDLE;
                    end else if (networkFinished) begin
                        acc   <= '0;
                        state <= FINAL;
                    end else if (activeNetwork != prev_net) begin
                        // The sample on a switch cycle belongs to the incoming network.
                        prev_net <= activeNetwork;
                        acc      <= inc;
                    end else begin
                        acc <= acc_next;
                        if (sum[SCORE_W]) scoreOverflow <= 1'b1;
                    end
                end
                FINAL: begin
                    if (networkState != 2'd1) begin
                        state <= IDLE;
                    end else begin
                        scoresValid <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: if (networkState != 2'd1) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                score_tbl[prev_net] <= acc;
                if (acc > bestScore) begin
                    bestScore   <= acc;
                    bestNetwork <= prev_net;
                end
            end
        end
    end
endmodule

// File: tb/tb_fitness_evaluator.sv
// Directed bench for fitness_evaluator with a scoreboard queue of expected values.
module tb_fitness_evaluator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  networkState = 2'd0;
    logic [3:0]  activeNetwork = 4'd0;
    logic        networkFinished = 1'b0;
    logic        sampleEn = 1'b0;
    logic [0:0]  nout = 1'b0;
    logic [0:0]  target = 1'b0;
    logic [3:0]  rdIndex = 4'd0;
    logic [15:0] rdScore;
    logic [3:0]  bestNetwork;
    logic [15:0] bestScore;
    logic        scoresValid;
    logic        scoreOverflow;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    int          exp_tbl[16];
    int          scores[16] = '{5, 9, 9, 3, 0, 7, 2, 8, 1, 0, 4, 6, 9, 3, 2, 5};

    fitness_evaluator #(.OUTPUT_COUNT(1), .NETWORKS_PER_POPULATION(16), .SCORE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .networkState(networkState), .activeNetwork(activeNetwork),
        .networkFinished(networkFinished), .sampleEn(sampleEn), .nout(nout), .target(target),
        .rdIndex(rdIndex), .rdScore(rdScore), .bestNetwork(bestNetwork), .bestScore(bestScore),
        .scoresValid(scoresValid), .scoreOverflow(scoreOverflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %0d but nothing expected", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    task automatic sample(input logic [3:0] net, input logic en, input logic match);
        activeNetwork = net;
        sampleEn      = en;
        target        = 1'($urandom_range(0, 1));
        nout          = match ? target : ~target;
        step();
    endtask

    // Network 4 never samples, network 9 never matches; the rest get s hits plus noise.
    task automatic drive_net(input int n, input int s);
        exp_tbl[n] = 0;
        if (n == 4) begin
            repeat (5) sample(4'(n), 1'b0, 1'b1);
        end else if (n == 9) begin
            repeat (4) sample(4'(n), 1'b1, 1'b0);
        end else begin
            repeat (s) begin
                sample(4'(n), 1'b1, 1'b1);
                exp_tbl[n]++;
            end
            sample(4'(n), 1'b1, 1'b0);
            sample(4'(n), 1'b0, 1'b1);
        end
    endtask

    task automatic start_run();
        networkState  = 2'd1;
        activeNetwork = 4'd0;
        sampleEn      = 1'b0;
        step();
    endtask

    // The finishing cycle carries a matching sample and a network change, both ignored.
    task automatic finish_run();
        networkFinished = 1'b1;
        activeNetwork   = 4'd3;
        sampleEn        = 1'b1;
        nout            = target;
        step();
        networkFinished = 1'b0;
        sampleEn        = 1'b0;
        push(0); check("valid_in_final", 32'(scoresValid));
        step();
        push(1); check("valid_in_done", 32'(scoresValid));
    endtask

    task automatic read_tbl(input int idx, input string tag);
        rdIndex = 4'(idx);
        step();
        push(32'(exp_tbl[idx]));
        check(tag, 32'(rdScore));
    endtask

    task automatic check_best(input string tag);
        int bn = 0;
        int bs = 0;
        for (int i = 0; i < 16; i++)
            if (exp_tbl[i] > bs) begin
                bs = exp_tbl[i];
                bn = i;
            end
        push(32'(bn)); check({tag, "_net"}, 32'(bestNetwork));
        push(32'(bs)); check({tag, "_score"}, 32'(bestScore));
    endtask

    task automatic full_run(input string tag);
        start_run();
        for (int n = 0; n < 16; n++) drive_net(n, scores[n]);
        finish_run();
        check_best(tag);
        push(0); check({tag, "_ovf"}, 32'(scoreOverflow));
        for (int i = 0; i < 16; i++) read_tbl(i, $sformatf("%s_tbl%0d", tag, i));
        networkState = 2'd0;
        step();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step();
        push(0); check("rst_rd", 32'(rdScore));
        push(0); check("rst_best_net", 32'(bestNetwork));
        push(0); check("rst_best_score", 32'(bestScore));
        push(0); check("rst_valid", 32'(scoresValid));
        push(0); check("rst_ovf", 32'(scoreOverflow));
        rst_n = 1'b1;
        step();

        full_run("run1");

        // Ten hits on network 0, then a switch commits it and makes it best.
        start_run();
        drive_net(0, 10);
        sample(4'd1, 1'b0, 1'b1);
        push(10); check("first_commit_score", 32'(bestScore));
        push(0);  check("first_commit_net", 32'(bestNetwork));
        drive_net(1, 4);
        drive_net(2, 6);
        drive_net(3, 7);
        sample(4'd4, 1'b1, 1'b1);
        networkState = 2'd0;
        step();
        push(0); check("abort_valid", 32'(scoresValid));
        read_tbl(3, "abort_tbl3");
        read_tbl(0, "abort_tbl0");

        // Asynchronous reset in the middle of network 7.
        start_run();
        for (int n = 0; n < 7; n++) drive_net(n, scores[n]);
        repeat (3) sample(4'd7, 1'b1, 1'b1);
        rdIndex = 4'd1;
        #2 rst_n = 1'b0;
        #1;
        push(0); check("midrst_rd", 32'(rdScore));
        push(0); check("midrst_best_net", 32'(bestNetwork));
        push(0); check("midrst_best_score", 32'(bestScore));
        push(0); check("midrst_valid", 32'(scoresValid));
        push(0); check("midrst_ovf", 32'(scoreOverflow));
        networkState = 2'd0;
        step();
        rst_n = 1'b1;
        step();
        full_run("rerun");

        // Long run on network 0 exercises overflow handling.
        start_run();
        repeat (70000) sample(4'd0, 1'b1, 1'b1);
        sample(4'd1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) exp_tbl[i] = 0;
`ifdef FITNESS_SATURATE_EN
        exp_tbl[0] = 65535;
`else
        exp_tbl[0] = 4464;
`endif
        finish_run();
        push(1); check("ovf_flag", 32'(scoreOverflow));
        check_best("ovf");
        read_tbl(0, "ovf_tbl0");
        networkState = 2'd0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
